// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder
// Sequential MIPS32 instruction encoder. Accepts abstract instruction
// commands over a valid/ready handshake and emits encoded 32-bit words,
// each tagged with a sequential word address. LI expands to LUI/ORI when
// the upper half is non-zero, and branch/jump kinds can be followed by a
// delay-slot NOP.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start,base_addr load the address counter (IDLE only)
//   cmd_*           command handshake and fields (kind, op, funct, rs, rt,
//                   rd, sa, imm)
//   out_valid/out_ready/out_data/out_addr  encoded word stream
//   err             sticky, illegal command kind seen
//   wrapped         sticky, address counter wrapped past 2^AW-1
module mips_inst_encoder #(
    parameter int AW       = 10,
    parameter int AUTO_NOP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_kind,
    input  logic [5:0]    cmd_op,
    input  logic [5:0]    cmd_funct,
    input  logic [4:0]    cmd_rs,
    input  logic [4:0]    cmd_rt,
    input  logic [4:0]    cmd_rd,
    input  logic [4:0]    cmd_sa,
    input  logic [31:0]   cmd_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [AW-1:0] out_addr,
    output logic          err,
    output logic          wrapped
);

    localparam logic NOP_EN = (AUTO_NOP != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          out_valid_reg, out_valid_next;
    logic [31:0]   out_data_reg, out_data_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [31:0]   second_reg, second_next;
    logic          has_second_reg, has_second_next;
    logic          err_reg, err_next;
    logic          wrapped_reg, wrapped_next;

    // One-hot decode of the legal kinds (0..7); anything else is illegal.
    logic [7:0] kind_hot;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_kind
            assign kind_hot[gi] = (cmd_kind == 4'(gi));
        end
    endgenerate

    logic kind_legal;
    logic kind_has_slot;
    assign kind_legal    = |kind_hot;
    assign kind_has_slot = kind_hot[2] | kind_hot[3] | kind_hot[4];

    // Encoding of the command currently on the input bus; it is captured
    // into out_data/second at acceptance, so later bus changes do not matter.
    logic [31:0] enc_word0;
    logic [31:0] enc_word1;
    logic        enc_two;

    always_comb begin
        enc_word0 = 32'h0;
        enc_word1 = 32'h0;
        enc_two   = 1'b0;
        case (cmd_kind)
            4'd0, 4'd4: enc_word0 = {6'h00, cmd_rs, cmd_rt, cmd_rd, cmd_sa, cmd_funct};
            4'd1, 4'd2: enc_word0 = {cmd_op, cmd_rs, cmd_rt, cmd_imm[15:0]};
            4'd3:       enc_word0 = {cmd_op, cmd_imm[25:0]};
            4'd5: begin
                if (cmd_imm[31:16] != 16'h0) begin
                    // LUI rt, hi ; ORI rt, rt, lo
                    enc_word0 = {6'h0F, 5'd0, cmd_rt, cmd_imm[31:16]};
                    enc_word1 = {6'h0D, cmd_rt, cmd_rt, cmd_imm[15:0]};
                    enc_two   = 1'b1;
                end else begin
                    // ORI rt, $zero, lo
                    enc_word0 = {6'h0D, 5'd0, cmd_rt, cmd_imm[15:0]};
                end
            end
            4'd6:    enc_word0 = {6'h10, cmd_rs, cmd_rt, cmd_rd, 11'd0};
            4'd7:    enc_word0 = 32'h4200_0018;
            default: enc_word0 = 32'h0;
        endcase
        if (NOP_EN && kind_has_slot) begin
            enc_word1 = 32'h0;
            enc_two   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 32'h0;
            addr_reg       <= '0;
            second_reg     <= 32'h0;
            has_second_reg <= 1'b0;
            err_reg        <= 1'b0;
            wrapped_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            addr_reg       <= addr_next;
            second_reg     <= second_next;
            has_second_reg <= has_second_next;
            err_reg        <= err_next;
            wrapped_reg    <= wrapped_next;
        end
    end

    logic handshake;
    assign handshake = out_valid_reg && out_ready;

    always_comb begin
        state_next      = state_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        addr_next       = addr_reg;
        second_next     = second_reg;
        has_second_next = has_second_reg;
        err_next        = err_reg;
        wrapped_next    = wrapped_reg;

        // out_valid is only ever high in W0/W1, so this never collides
        // with the start load below.
        if (handshake) begin
            addr_next = addr_reg + 1'b1;
            if (addr_reg == '1) begin
                wrapped_next = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                // Loading the counter alongside acceptance means word 0
                // goes out at base_addr.
                if (start) begin
                    addr_next = base_addr;
                end
                if (cmd_valid) begin
                    if (!kind_legal) begin
                        err_next = 1'b1;
                    end else begin
                        out_data_next   = enc_word0;
                        second_next     = enc_word1;
                        has_second_next = enc_two;
                        out_valid_next  = 1'b1;
                        state_next      = W0;
                    end
                end
            end
            W0: begin
                if (out_ready) begin
                    if (has_second_reg) begin
                        out_data_next = second_reg;
                        state_next    = W1;
                    end else begin
                        out_valid_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
            end
            W1: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                out_valid_next = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_addr  = addr_reg;
    assign err       = err_reg;
    assign wrapped   = wrapped_reg;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Directed bench for mips_inst_encoder. Three instances share the command
// fields: dut0 (AW=10, AUTO_NOP=1), dut1 (AW=10, AUTO_NOP=0), dut2 (AW=4).
module tb_mips_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  valid_v;
    logic [9:0]  base10;
    logic [3:0]  base4;
    logic [3:0]  kind;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [31:0] imm;
    logic        out_ready;

    logic [2:0]  rdy, ovv, errv, wrapv;
    logic [31:0] od0, od1, od2;
    logic [9:0]  oa0, oa1;
    logic [3:0]  oa2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_inst_encoder #(.AW(10), .AUTO_NOP(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .base_addr(base10),
        .cmd_valid(valid_v[0]), .cmd_ready(rdy[0]), .cmd_kind(kind),
        .cmd_op(op), .cmd_funct(funct), .cmd_rs(rs), .cmd_rt(rt), .cmd_rd(rd),
        .cmd_sa(sa), .cmd_imm(imm), .out_valid(ovv[0]), .out_ready(out_ready),
        .out_data(od0), .out_addr(oa0), .err(errv[0]), .wrapped(wrapv[0]));

    mips_inst_encoder #(.AW(10), .AUTO_NOP(0)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .base_addr(base10),
        .cmd_valid(valid_v[1]), .cmd_ready(rdy[1]), .cmd_kind(kind),
        .cmd_op(op), .cmd_funct(funct), .cmd_rs(rs), .cmd_rt(rt), .cmd_rd(rd),
        .cmd_sa(sa), .cmd_imm(imm), .out_valid(ovv[1]), .out_ready(out_ready),
        .out_data(od1), .out_addr(oa1), .err(errv[1]), .wrapped(wrapv[1]));

    mips_inst_encoder #(.AW(4), .AUTO_NOP(1)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .base_addr(base4),
        .cmd_valid(valid_v[2]), .cmd_ready(rdy[2]), .cmd_kind(kind),
        .cmd_op(op), .cmd_funct(funct), .cmd_rs(rs), .cmd_rt(rt), .cmd_rd(rd),
        .cmd_sa(sa), .cmd_imm(imm), .out_valid(ovv[2]), .out_ready(out_ready),
        .out_data(od2), .out_addr(oa2), .err(errv[2]), .wrapped(wrapv[2]));

    function automatic logic [31:0] get_data(int s);
        case (s)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

    function automatic logic [31:0] get_addr(int s);
        case (s)
            0:       return {22'b0, oa0};
            1:       return {22'b0, oa1};
            default: return {28'b0, oa2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one command to instance s for a single cycle.
    task automatic issue(input int s, input logic [3:0] k, input logic [5:0] o,
                         input logic [5:0] f, input logic [4:0] r_s, input logic [4:0] r_t,
                         input logic [4:0] r_d, input logic [31:0] im, input logic st);
        kind = k; op = o; funct = f; rs = r_s; rt = r_t; rd = r_d; sa = 5'd0; imm = im;
        start_v[s] = st;
        valid_v[s] = 1'b1;
        chk("ready_at_issue", {31'b0, rdy[s]}, 32'd1);
        @(negedge clk);
        valid_v[s] = 1'b0;
        start_v[s] = 1'b0;
    endtask

    // Wait (bounded) for a word from instance s and check it; out_ready is high.
    task automatic take(input int s, input string tag, input logic [31:0] data,
                        input logic [31:0] addr);
        int n = 0;
        while (!ovv[s] && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'b0, ovv[s]}, 32'd1);
        chk({tag, "_data"}, get_data(s), data);
        chk({tag, "_addr"}, get_addr(s), addr);
        $display("txn dut%0d %s data=%h addr=%h", s, tag, get_data(s), get_addr(s));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start_v = 3'b0; valid_v = 3'b0; base10 = 10'h0; base4 = 4'h0;
        kind = 4'd0; op = 6'd0; funct = 6'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
        sa = 5'd0; imm = 32'h0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", {31'b0, rdy[0]}, 32'd1);
        chk("rst_valid", {31'b0, ovv[0]}, 32'd0);
        chk("rst_data", od0, 32'h0);
        chk("rst_addr", {22'b0, oa0}, 32'h0);
        chk("rst_err", {31'b0, errv[0]}, 32'd0);
        chk("rst_wrapped", {31'b0, wrapv[0]}, 32'd0);

        // ADDU with start at 0x10; cmd_ready returns two cycles after acceptance
        base10 = 10'h010;
        issue(0, 4'd0, 6'd0, 6'h21, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
        chk("addu_ready_busy", {31'b0, rdy[0]}, 32'd0);
        take(0, "addu", 32'h0022_1821, 32'h10);
        chk("addu_ready_back", {31'b0, rdy[0]}, 32'd1);
        chk("addu_done", {31'b0, ovv[0]}, 32'd0);

        // LI with upper half -> LUI, ORI
        issue(0, 4'd5, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 1'b0);
        take(0, "li_lui", 32'h3C08_1234, 32'h11);
        take(0, "li_ori", 32'h3508_5678, 32'h12);

        // LI with zero upper half -> single ORI
        issue(0, 4'd5, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 32'h0000_FFFF, 1'b0);
        take(0, "li_short", 32'h3408_FFFF, 32'h13);
        chk("li_short_single", {31'b0, ovv[0]}, 32'd0);

        // Branch and jump with delay-slot NOP
        issue(0, 4'd2, 6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 32'h4, 1'b0);
        take(0, "beq", 32'h1022_0004, 32'h14);
        take(0, "beq_nop", 32'h0, 32'h15);
        issue(0, 4'd3, 6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 1'b0);
        take(0, "jal", 32'h0C10_0000, 32'h16);
        take(0, "jal_nop", 32'h0, 32'h17);

        // COP0 and ERET
        issue(0, 4'd6, 6'd0, 6'd0, 5'd4, 5'd4, 5'd12, 32'h0, 1'b0);
        take(0, "mtc0", 32'h4084_6000, 32'h18);
        issue(0, 4'd7, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        take(0, "eret", 32'h4200_0018, 32'h19);

        // Illegal kind: consumed, err set, nothing emitted
        issue(0, 4'd15, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        chk("ill_no_valid", {31'b0, ovv[0]}, 32'd0);
        chk("ill_err", {31'b0, errv[0]}, 32'd1);
        chk("ill_ready", {31'b0, rdy[0]}, 32'd1);
        issue(0, 4'd0, 6'd0, 6'h21, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        take(0, "after_ill", 32'h0022_1821, 32'h1A);
        chk("err_sticky", {31'b0, errv[0]}, 32'd1);

        // Backpressure during LI: three cycles of out_ready low
        out_ready = 1'b0;
        issue(0, 4'd5, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'b0, ovv[0]}, 32'd1);
            chk("bp_data", od0, 32'h3C08_1234);
            chk("bp_addr", {22'b0, oa0}, 32'h1B);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ori_data", od0, 32'h3508_5678);
        chk("bp_ori_addr", {22'b0, oa0}, 32'h1C);
        $display("txn dut0 bp_ori data=%h addr=%h", od0, oa0);

        // Reset pulse while in W1: outputs clear immediately
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstw1_valid", {31'b0, ovv[0]}, 32'd0);
        chk("rstw1_data", od0, 32'h0);
        chk("rstw1_addr", {22'b0, oa0}, 32'h0);
        chk("rstw1_err", {31'b0, errv[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstw1_no_partial", {31'b0, ovv[0]}, 32'd0);
        end
        chk("rstw1_ready", {31'b0, rdy[0]}, 32'd1);

        // AUTO_NOP=0: only the first word of branch and jump
        issue(1, 4'd2, 6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 32'h4, 1'b0);
        take(1, "nn_beq", 32'h1022_0004, 32'h0);
        chk("nn_beq_single", {31'b0, ovv[1]}, 32'd0);
        issue(1, 4'd3, 6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 1'b0);
        take(1, "nn_jal", 32'h0C10_0000, 32'h1);
        chk("nn_jal_single", {31'b0, ovv[1]}, 32'd0);

        // AW=4 wrap: LI starting at address 15
        chk("wrap_before", {31'b0, wrapv[2]}, 32'd0);
        base4 = 4'd15;
        issue(2, 4'd5, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 1'b1);
        take(2, "wrap_lui", 32'h3C08_1234, 32'hF);
        take(2, "wrap_ori", 32'h3508_5678, 32'h0);
        chk("wrap_flag", {31'b0, wrapv[2]}, 32'd1);
        chk("wrap_addr_after", {28'b0, oa2}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_inst_encoder.md
# mips_inst_encoder

Sequential MIPS32 instruction encoder. It is the producing end of the instruction format that the main decoder consumes. It accepts abstract instruction commands over a valid/ready handshake and emits encoded 32-bit instruction words with sequential word addresses. Two features make it multi-word:
- The LI pseudo-instruction expands to LUI/ORI.
- Branch and jump kinds get an optional delay-slot NOP.

It feeds the instruction-memory loader used by self-test and boot-ROM generation.

## Interface
- `AW`, default 10: word-address width of `out_addr`.
- `AUTO_NOP`, default 1: when 1, a NOP (`0x00000000`) is appended after every branch/jump kind.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `start` in 1: loads `base_addr` into the address counter. Honoured only in IDLE.
- `base_addr` in AW: start address.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: encoder can accept a command.
- `cmd_kind` in 4: 0 R, 1 I, 2 I-branch, 3 J, 4 R-jump, 5 LI, 6 COP0, 7 ERET. Values 8–15 are illegal.
- `cmd_op` in 6, `cmd_funct` in 6: opcode and function fields.
- `cmd_rs`, `cmd_rt`, `cmd_rd`, `cmd_sa` in 5 each: register and shift-amount fields.
- `cmd_imm` in 32: immediate, jump target, or LI value.
- `out_valid` out 1: `out_data`/`out_addr` are valid.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out 32: encoded instruction.
- `out_addr` out AW: word address of `out_data`.
- `err` out 1: sticky; set when an illegal kind is received.
- `wrapped` out 1: sticky; set when the address counter wraps.

## Operation
Encoding, evaluated on the latched command:
- Kind 0 (R): `{6'h00, rs, rt, rd, sa, funct}`.
- Kind 1 (I) and kind 2 (I-branch): `{op, rs, rt, imm[15:0]}`. This covers ALU-immediate, load/store, BEQ/BNE/BLEZ/BGTZ and REGIMM (rt carries BLTZ/BGEZ/…AL).
- Kind 3 (J): `{op, imm[25:0]}`.
- Kind 4 (R-jump): same as kind 0.
- Kind 5 (LI `rt`, `imm`):
  - If `imm[31:16] != 0`: emit LUI `{6'h0F, 5'd0, rt, imm[31:16]}`, then ORI `{6'h0D, rt, rt, imm[15:0]}`.
  - Otherwise emit a single ORI `{6'h0D, 5'd0, rt, imm[15:0]}`.
- Kind 6 (COP0): `{6'h10, rs, rt, rd, 11'd0}`. `rs` is 00000 for MFC0 and 00100 for MTC0.
- Kind 7 (ERET): `32'h42000018`.
- Kinds 2, 3 and 4 with `AUTO_NOP=1`: a second word `0x00000000` follows.
- Illegal kind: the command is consumed, `err` is set, and no word is emitted.

FSM states: IDLE, W0, W1.
- IDLE:
  - `cmd_ready=1`.
  - `start` loads `base_addr`.
  - On `cmd_valid`: latch the command, load word 0 into `out_data`, set `out_valid=1`, go to W0. For an illegal kind, stay in IDLE.
- W0:
  - On `out_ready`, if a second word is pending: load it, keep `out_valid=1`, go to W1.
  - On `out_ready` otherwise: `out_valid=0`, go to IDLE.
- W1:
  - On `out_ready`: `out_valid=0`, go to IDLE.
- The address counter increments by 1 on every `out_valid && out_ready` handshake. It wraps modulo 2^AW; on wrap `wrapped` is set.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `out_valid=0`, `out_data=0`, `out_addr=0`, `err=0`, `wrapped=0`.
- Latency from command acceptance to `out_valid`: 1 cycle.
- Throughput: a single-word command completes in 2 cycles minimum; a two-word command in 3.
- `cmd_ready` is 0 in W0 and W1.
- While `out_valid=1 && out_ready=0`, `out_data` and `out_addr` are held stable.
- `start` together with `cmd_valid` in IDLE: the address loads first, and word 0 is emitted at `base_addr`.
- `start` outside IDLE is ignored.
- Reset asserted mid-command: the command is abandoned, all outputs return to reset values immediately, and no partial second word is emitted after release.
- `err` and `wrapped` clear only on reset.

## Test plan
- `start`, `base_addr=0x10`; kind 0 with rs=1, rt=2, rd=3, funct=0x21 (ADDU) -> `out_data=0x00221821` at `out_addr=0x10`; `cmd_ready` is back to 1 two cycles after acceptance.
- Kind 5, rt=8, imm=`0x12345678` -> `0x3C081234` at addr n, then `0x35085678` at addr n+1. Imm=`0x0000FFFF` -> single word `0x3408FFFF`.
- Kind 2, op=4, rs=1, rt=2, imm=4, `AUTO_NOP=1` -> `0x10220004` then `0x00000000`. Kind 3, op=3, imm=`0x0100000` -> `0x0C100000` then NOP. With `AUTO_NOP=0`, only the first word of each is emitted.
- Kind 6, rs=4, rt=4, rd=12 -> `0x40846000`. Kind 7 -> `0x42000018`. Kind 15 -> `err=1`, no `out_valid`, and the next legal command is still encoded correctly.
- Backpressure: `out_ready` held low 3 cycles during an LI -> `out_data` and `out_addr` stable, no address increment. Reset pulse in W1 -> `out_valid=0` immediately.
- `AW=4`, `base_addr=15`, LI with a nonzero upper half -> words at addr 15 then 0, and `wrapped=1`.
